// File: rtl/melody_if.sv
// Control/status bundle between the prelude top level and the melody sequencer.
// The top level drives start/stop/loop. The sequencer returns the tone code and status.
interface melody_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] frequency;
  logic [4:0] note_idx;
  logic       note_strobe;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, loop,
    input  frequency, note_idx, note_strobe, busy, done
  );

  modport slave (
    input  start, stop, loop,
    output frequency, note_idx, note_strobe, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps a fixed 20-note melody ROM and drives the sine generator's pitch code.
// The last GAP_CYCLES of every slot is a rest, so that repeated pitches are articulated.
module melody_sequencer #(
  parameter int EIGHTH_CYCLES = 3_000_000,
  parameter int GAP_CYCLES    = 120_000
) (
  input  logic     clk,
  input  logic     reset,
  melody_if.slave  bus
);
  localparam int              CW        = (EIGHTH_CYCLES > 1) ? $clog2(EIGHTH_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST_CYC  = CW'(EIGHTH_CYCLES - 1);
  localparam logic [CW-1:0]   PLAY_LAST = CW'(EIGHTH_CYCLES - 1 - GAP_CYCLES);
  localparam logic [4:0]      LAST_NOTE = 5'd19;
  localparam logic [3:0]      REST      = 4'd15;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc_cnt, cyc_n;
  logic [3:0]    eighth_left, left_n;
  logic [4:0]    note_idx, idx_n;
  logic [3:0]    freq_n;
  logic          strobe_n, done_n, advance, go_idle;

  // Pitch codes: A=0 Dhigh=1 C=2 B=3 G=4 Fis=5 E=6 D=7
  function automatic logic [3:0] pitch_of(input logic [4:0] i);
    case (i)
      5'd0:  pitch_of = 4'd7;
      5'd1:  pitch_of = 4'd4;
      5'd2:  pitch_of = 4'd4;
      5'd3:  pitch_of = 4'd0;
      5'd4:  pitch_of = 4'd3;
      5'd5:  pitch_of = 4'd4;
      5'd6:  pitch_of = 4'd1;
      5'd7:  pitch_of = 4'd3;
      5'd8:  pitch_of = 4'd3;
      5'd9:  pitch_of = 4'd2;
      5'd10: pitch_of = 4'd1;
      5'd11: pitch_of = 4'd2;
      5'd12: pitch_of = 4'd3;
      5'd13: pitch_of = 4'd2;
      5'd14: pitch_of = 4'd1;
      5'd15: pitch_of = 4'd0;
      5'd16: pitch_of = 4'd4;
      5'd17: pitch_of = 4'd0;
      5'd18: pitch_of = 4'd3;
      5'd19: pitch_of = 4'd0;
      default: pitch_of = REST;
    endcase
  endfunction

  function automatic logic [3:0] dur_raw(input logic [4:0] i);
    case (i)
      5'd0, 5'd5, 5'd6, 5'd11, 5'd14: dur_raw = 4'd2;
      5'd19:                          dur_raw = 4'd4;
      default:                        dur_raw = 4'd1;
    endcase
  endfunction

  // A zero duration would underflow the eighths counter, so it plays as one eighth.
  function automatic logic [3:0] dur_of(input logic [4:0] i);
    logic [3:0] d;
    d = dur_raw(i);
    dur_of = (d == 4'd0) ? 4'd1 : d;
  endfunction

  always_comb begin
    state_n  = state;
    cyc_n    = cyc_cnt + CW'(1);
    left_n   = eighth_left;
    idx_n    = note_idx;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    advance  = 1'b0;
    go_idle  = 1'b0;

    if (cyc_cnt == LAST_CYC) begin
      cyc_n  = '0;
      left_n = eighth_left - 4'd1;
    end

    case (state)
      IDLE: begin
        cyc_n  = '0;
        left_n = '0;
        idx_n  = '0;
        if (bus.start && !bus.stop) begin
          state_n  = PLAY;
          left_n   = dur_of(5'd0);
          strobe_n = 1'b1;
        end
      end
      PLAY: begin
        if (bus.stop)
          go_idle = 1'b1;
        else if (eighth_left == 4'd1 && cyc_cnt == PLAY_LAST) begin
          // Without a rest, the end of PLAY is also the end of the slot.
          if (GAP_CYCLES == 0) advance = 1'b1;
          else                 state_n = GAP;
        end
      end
      GAP: begin
        if (bus.stop)
          go_idle = 1'b1;
        else if (eighth_left == 4'd1 && cyc_cnt == LAST_CYC)
          advance = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (advance) begin
      state_n  = PLAY;
      cyc_n    = '0;
      strobe_n = 1'b1;
      if (note_idx == LAST_NOTE) begin
        idx_n = '0;
        if (!bus.loop) begin
          state_n  = IDLE;
          strobe_n = 1'b0;
          done_n   = 1'b1;
        end
      end else begin
        idx_n = note_idx + 5'd1;
      end
      left_n = (state_n == PLAY) ? dur_of(idx_n) : 4'd0;
    end

    if (go_idle) begin
      state_n = IDLE;
      cyc_n   = '0;
      left_n  = '0;
      idx_n   = '0;
    end

    freq_n = (state_n == PLAY) ? pitch_of(idx_n) : REST;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      cyc_cnt         <= '0;
      eighth_left     <= '0;
      note_idx        <= '0;
      bus.frequency   <= REST;
      bus.note_idx    <= '0;
      bus.note_strobe <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state           <= state_n;
      cyc_cnt         <= cyc_n;
      eighth_left     <= left_n;
      note_idx        <= idx_n;
      bus.frequency   <= freq_n;
      bus.note_idx    <= idx_n;
      bus.note_strobe <= strobe_n;
      bus.busy        <= (state_n != IDLE);
      bus.done        <= done_n;
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances (gap 2 and gap 0) share the same stimulus.
// Every cycle is compared against a slot-timeline model built from the melody tables.
module tb_melody_sequencer;
  localparam int E     = 8;
  localparam int TOTAL = 28 * E;
  localparam logic [11:0] IDLE_V = {4'hf, 5'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] DONE_V = {4'hf, 5'd0, 1'b0, 1'b0, 1'b1};

  logic clk, reset, start, stop, loop;
  int   errors = 0;
  int   checks = 0;

  int P[20]    = '{7,4,4,0,3,4,1,3,3,2,1,2,3,2,1,0,4,0,3,0};
  int D[20]    = '{2,1,1,1,1,2,2,1,1,1,1,2,1,1,2,1,1,1,1,4};
  int GAPS[2]  = '{2, 0};

  melody_if m0();
  melody_if m1();
  assign m0.start = start; assign m0.stop = stop; assign m0.loop = loop;
  assign m1.start = start; assign m1.stop = stop; assign m1.loop = loop;

  melody_sequencer #(.EIGHTH_CYCLES(E), .GAP_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(m0.slave));
  melody_sequencer #(.EIGHTH_CYCLES(E), .GAP_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(m1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {frequency, note_idx, note_strobe, busy, done}
  function automatic logic [11:0] obs(input int d);
    if (d == 0) return {m0.frequency, m0.note_idx, m0.note_strobe, m0.busy, m0.done};
    return {m1.frequency, m1.note_idx, m1.note_strobe, m1.busy, m1.done};
  endfunction

  // Locate cycle t (counted from the first PLAY cycle, wrapping per pass) inside the slot timeline.
  function automatic logic [11:0] expv(input int t, input int gap);
    int base, tt, f, idx, stb, len;
    base = 0; tt = t % TOTAL; f = 15; idx = 0; stb = 0;
    for (int k = 0; k < 20; k++) begin
      len = D[k] * E;
      if (tt >= base && tt < base + len) begin
        idx = k;
        f   = (tt - base < len - gap) ? P[k] : 15;
        stb = (tt == base) ? 1 : 0;
      end
      base += len;
    end
    return {f[3:0], idx[4:0], stb[0], 1'b1, 1'b0};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    repeat (3) tick;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== IDLE_V) begin
        errors++; $display("FAIL reset dut%0d got=%h exp=%h", d, obs(d), IDLE_V);
      end
    end
    reset = 1'b1;
    tick;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== IDLE_V) begin
        errors++; $display("FAIL reset_release dut%0d got=%h exp=%h", d, obs(d), IDLE_V);
      end
    end
  endtask

  task automatic test_single_pass;
    int nstb[2];
    nstb = '{0, 0};
    loop = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int t = 0; t <= TOTAL; t++) begin
      for (int d = 0; d < 2; d++) begin
        logic [11:0] e;
        e = (t < TOTAL) ? expv(t, GAPS[d]) : DONE_V;
        checks++;
        if (obs(d) !== e) begin
          errors++; $display("FAIL single_pass dut%0d t=%0d got=%h exp=%h", d, t, obs(d), e);
        end
        if (obs(d) & 12'h004) nstb[d]++;
      end
      tick;
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== IDLE_V) begin
        errors++; $display("FAIL done_single dut%0d got=%h exp=%h", d, obs(d), IDLE_V);
      end
      checks++;
      if (nstb[d] != 20) begin
        errors++; $display("FAIL strobe_count dut%0d got=%0d exp=20", d, nstb[d]);
      end
    end
  endtask

  task automatic test_loop;
    start = 1'b1; tick; start = 1'b0;
    for (int t = 0; t < TOTAL + 16; t++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(t, GAPS[d])) begin
          errors++; $display("FAIL loop dut%0d t=%0d got=%h exp=%h", d, t, obs(d), expv(t, GAPS[d]));
        end
      end
      // loop only matters on the last cycle of note 19; elsewhere it is noise
      loop = (t == TOTAL - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      tick;
    end
    stop = 1'b1; tick; stop = 1'b0; loop = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== IDLE_V) begin
        errors++; $display("FAIL loop_stop dut%0d got=%h exp=%h", d, obs(d), IDLE_V);
      end
    end
  endtask

  task automatic test_stop;
    int ts;
    ts = $urandom_range(48, 61);
    start = 1'b1; tick; start = 1'b0;
    for (int t = 0; t <= ts; t++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(t, GAPS[d])) begin
          errors++; $display("FAIL pre_stop dut%0d t=%0d got=%h exp=%h", d, t, obs(d), expv(t, GAPS[d]));
        end
      end
      if (t == ts) stop = 1'b1;
      tick;
    end
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== IDLE_V) begin
          errors++; $display("FAIL stop dut%0d c=%0d got=%h exp=%h", d, c, obs(d), IDLE_V);
        end
      end
      tick;
    end
    start = 1'b1; tick; start = 1'b0;
    for (int t = 0; t < 20; t++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(t, GAPS[d])) begin
          errors++; $display("FAIL restart dut%0d t=%0d got=%h exp=%h", d, t, obs(d), expv(t, GAPS[d]));
        end
      end
      tick;
    end
    stop = 1'b1; tick; stop = 1'b0;
  endtask

  task automatic test_start_busy;
    int tp;
    tp = $urandom_range(32, 39);
    start = 1'b1; tick; start = 1'b0;
    for (int t = 0; t <= TOTAL; t++) begin
      for (int d = 0; d < 2; d++) begin
        logic [11:0] e;
        e = (t < TOTAL) ? expv(t, GAPS[d]) : DONE_V;
        checks++;
        if (obs(d) !== e) begin
          errors++; $display("FAIL start_busy dut%0d t=%0d got=%h exp=%h", d, t, obs(d), e);
        end
      end
      start = (t == tp) || (t < TOTAL && $urandom_range(0, 7) == 0);
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_start_stop_idle;
    int n;
    n = $urandom_range(2, 6);
    start = 1'b1; stop = 1'b1;
    for (int c = 0; c <= n; c++) begin
      tick;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== IDLE_V) begin
          errors++; $display("FAIL start_stop dut%0d c=%0d got=%h exp=%h", d, c, obs(d), IDLE_V);
        end
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset_mid;
    int tr;
    tr = $urandom_range(104, 111);
    start = 1'b1; tick; start = 1'b0;
    for (int t = 0; t <= tr; t++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== expv(t, GAPS[d])) begin
          errors++; $display("FAIL pre_reset dut%0d t=%0d got=%h exp=%h", d, t, obs(d), expv(t, GAPS[d]));
        end
      end
      if (t == tr) reset = 1'b0;
      tick;
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== IDLE_V) begin
          errors++; $display("FAIL reset_mid dut%0d c=%0d got=%h exp=%h", d, c, obs(d), IDLE_V);
        end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single_pass;
    test_loop;
    test_stop;
    test_start_busy;
    test_start_stop_idle;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
